// File: rtl/crc16_frame_appender.sv
// Streaming CRC-16 appender: forwards 16-bit payload words and follows each frame
// with its CRC word (non-reflected, MSB-first, no final XOR), marked with m_last.
module crc16_frame_appender #(
    parameter logic [15:0] INIT    = 16'hFFFF,
    parameter logic [15:0] POLY    = 16'h1021,
    parameter int          MAX_LEN = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [15:0] m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic [15:0] crc_out,
    output logic [15:0] frame_count,
    output logic        trunc_err
);

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    typedef enum logic {
        ST_PAYLOAD,
        ST_APPEND
    } state_t;

    state_t      r_state;
    logic [15:0] r_crc;
    logic [15:0] r_count;
    logic [15:0] r_m_data;
    logic        r_m_valid;
    logic        r_m_last;
    logic [15:0] r_frame_count;
    logic        r_trunc_err;

    logic        w_load_ok;
    logic        w_s_ready;
    logic        w_accept;
    logic        w_at_max;
    logic [15:0] w_count_inc;
    logic [15:0] w_crc_next;

    // Sixteen serial shift steps of the LFSR, one per data bit, MSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [15:0] word);
        logic [15:0] c;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ word[i]) begin
                c = {c[14:0], 1'b0} ^ POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    assign w_load_ok   = ~r_m_valid | m_ready;
    assign w_s_ready   = (r_state == ST_PAYLOAD) & w_load_ok;
    assign w_accept    = s_valid & w_s_ready;
    assign w_count_inc = r_count + 16'd1;
    assign w_at_max    = (w_count_inc == MAX_LEN_W);
    assign w_crc_next  = crc_step(r_crc, s_data);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_PAYLOAD;
            r_crc         <= INIT;
            r_count       <= 16'd0;
            r_m_data      <= 16'd0;
            r_m_valid     <= 1'b0;
            r_m_last      <= 1'b0;
            r_frame_count <= 16'd0;
            r_trunc_err   <= 1'b0;
        end else begin
            r_trunc_err <= 1'b0;
            if (r_m_valid & m_ready & r_m_last) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            case (r_state)
                ST_PAYLOAD: begin
                    if (w_accept) begin
                        r_m_data  <= s_data;
                        r_m_valid <= 1'b1;
                        r_m_last  <= 1'b0;
                        r_crc     <= w_crc_next;
                        r_count   <= w_count_inc;
                        if (s_last | w_at_max) begin
                            r_state <= ST_APPEND;
                        end
                        // Only a length-forced close is an error; s_last on word MAX_LEN is fine.
                        if (w_at_max & ~s_last) begin
                            r_trunc_err <= 1'b1;
                        end
                    end else if (w_load_ok) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                    end
                end
                ST_APPEND: begin
                    if (w_load_ok) begin
                        r_m_data  <= r_crc;
                        r_m_valid <= 1'b1;
                        r_m_last  <= 1'b1;
                        r_crc     <= INIT;
                        r_count   <= 16'd0;
                        r_state   <= ST_PAYLOAD;
                    end
                end
                default: begin
                    r_state <= ST_PAYLOAD;
                end
            endcase
        end
    end

    assign s_ready     = w_s_ready;
    assign m_data      = r_m_data;
    assign m_valid     = r_m_valid;
    assign m_last      = r_m_last;
    assign crc_out     = r_crc;
    assign frame_count = r_frame_count;
    assign trunc_err   = r_trunc_err;

endmodule

// File: doc/crc16_frame_appender.md
Name: crc16_frame_appender

Overview:
Streaming stage that accepts a frame of 16-bit payload words over a valid/ready handshake and forwards each word unchanged. After the last payload word it appends one 16-bit CRC word and marks that word as the end of the frame. The CRC is computed internally, with the same algorithm as crc16_parallel, one word per clock. The block sits directly downstream of the payload source and feeds the serializer/link stage.

Parameters:
INIT, 16'hFFFF, CRC register value at the start of every frame
POLY, 16'h1021, generator polynomial (x^16 term implicit)
MAX_LEN, 1024, maximum payload words per frame before forced termination (range 1..65535)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
s_data  input  16  payload word
s_valid  input  1  s_data is valid
s_last  input  1  s_data is the final payload word of the frame
s_ready  output  1  block accepts s_data this cycle
m_data  output  16  output word (payload or CRC)
m_valid  output  1  m_data is valid
m_last  output  1  m_data is the appended CRC word
m_ready  input  1  downstream accepts m_data
crc_out  output  16  running CRC (CRC-so-far of the current frame)
frame_count  output  16  number of completed frames, counted when the CRC word is accepted
trunc_err  output  1  one-cycle pulse when a frame is force-terminated at MAX_LEN

Behaviour:
- CRC arithmetic: non-reflected, MSB-first, no final XOR. Each accepted word updates crc = f(crc, word) as 16 serial shift steps, unrolled combinationally.
- Frame property: CRC over payload||CRC word is 16'h0000.
- Reset (reset=0, async):
  - m_valid=0, m_last=0, m_data=0, trunc_err=0, frame_count=0.
  - crc=INIT, word counter=0, state=PAYLOAD.
  - Release is synchronous to clk.
- Output register: m_data, m_valid and m_last are registered. load_ok = ~m_valid | m_ready.
- State PAYLOAD:
  - s_ready = load_ok.
  - Input accept (s_valid & s_ready): m_data<=s_data, m_valid<=1, m_last<=0, crc<=f(crc,s_data), counter++.
  - Latency is 1 cycle from input acceptance to m_valid.
  - If load_ok and no input is accepted, m_valid<=0.
- Leaving PAYLOAD: an accepted word with s_last=1, or an accepted word that is number MAX_LEN, moves the state to APPEND.
  - If MAX_LEN is reached with s_last=0, trunc_err pulses for 1 cycle, in the cycle after acceptance.
- State APPEND:
  - s_ready=0.
  - When load_ok: m_data<=crc (the value including the last word), m_valid<=1, m_last<=1, crc<=INIT, counter<=0, state<=PAYLOAD.
  - Minimum gap: the CRC word appears exactly 1 cycle after the last payload word if m_ready stays high.
- frame_count increments by 1 when m_valid & m_ready & m_last. It wraps from 16'hFFFF to 0.
- Backpressure: while m_valid & ~m_ready, m_data, m_valid and m_last hold stable, and s_ready=0. No word is ever lost or duplicated.
- Simultaneous events:
  - Downstream acceptance and a new load in the same cycle are legal. This gives full throughput of 1 word/cycle, plus 1 CRC cycle per frame.
  - A new frame's first word may be accepted in the cycle after the CRC word is loaded.
- Single-word frame: the first word accepted with s_last=1 gives payload, then CRC, on consecutive cycles.
- Reset mid-frame: the partial frame is discarded, any pending output is dropped (m_valid=0), and the CRC is reinitialized.
- s_last is ignored when s_valid=0. Input signals are don't-care when s_ready=0.

Test Plan:
- INIT=0: single word 16'h0001 with s_last=1, m_ready=1 -> m_data 16'h0001, then 16'h1021 with m_last=1, on consecutive cycles; frame_count=1.
- INIT=0: single word 16'h0000 -> CRC word 16'h0000; m_last asserted only on the CRC word.
- Default INIT: 4-word frame 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0 -> appended CRC matches the bit-serial reference model, and a reference CRC over all 5 output words = 16'h0000.
- Random m_ready backpressure (50%) across 3 back-to-back frames -> output equals input payload with a CRC inserted per frame, no drops or duplicates, m_data stable while stalled, frame_count=3.
- MAX_LEN=4, 6 words sent with no s_last -> CRC appended after word 4, trunc_err pulses once, words 5-6 form the next frame.
- Reset low during word 2 of a frame -> outputs return to their reset values immediately; the next frame's CRC equals that of a fresh frame.
